sobel_stream: RTL

SOBEL_STREAM -- requirements
Module: sobel_stream

---
 rtl/sobel_stream.sv | 137 +++++++++++++
 1 files changed

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge-magnitude engine: column window, gradient stage, magnitude stage.
// Two-deep valid/ready pipeline with full-throughput backpressure.
module sobel_stream #(
  parameter int unsigned PIXEL_WIDTH_IN  = 8,
  parameter int unsigned PIXEL_WIDTH_OUT = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [3*PIXEL_WIDTH_IN-1:0]  col_i,
  input  logic                         col_sol_i,
  input  logic                         col_valid_i,
  output logic                         col_ready_o,
  input  logic [1:0]                   mode_i,
  input  logic [PIXEL_WIDTH_OUT-1:0]   threshold_i,
  output logic [PIXEL_WIDTH_OUT-1:0]   out_pixel_o,
  output logic                         out_sol_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i
);

  localparam int unsigned PW  = PIXEL_WIDTH_IN;
  localparam int unsigned PWO = PIXEL_WIDTH_OUT;
  localparam int unsigned GW  = PW + 3;
  localparam int unsigned WW  = (GW > PWO) ? GW : PWO;
  localparam logic [WW-1:0] MaxOut = WW'({PWO{1'b1}});

  logic [3*PW-1:0]        r_col0, r_col1, r_col2;
  logic [1:0]             r_fill;
  logic                   r_s1_valid;
  logic signed [GW-1:0]   r_gx, r_gy;
  logic [1:0]             r_s1_mode;
  logic [PWO-1:0]         r_s1_thr;
  logic                   r_s1_sol;
  logic                   r_out_valid;
  logic [PWO-1:0]         r_out_pixel;
  logic                   r_out_sol;

  logic                   w_s1_load, w_s2_load, w_accept, w_issue, w_issue_sol;
  logic [1:0]             w_fill_next;
  logic [PW-1:0]          w_c0 [3];
  logic [PW-1:0]          w_c1 [3];
  logic [PW-1:0]          w_c2 [3];
  logic signed [GW-1:0]   w_gx, w_gy;
  logic [GW-1:0]          w_ax, w_ay, w_sum, w_max;
  logic [WW-1:0]          w_sum_w, w_max_w, w_thr_w;
  logic [PWO-1:0]         w_pixel_next;

  function automatic logic signed [GW-1:0] ext(input logic [PW-1:0] p);
    return $signed({3'b000, p});
  endfunction

  function automatic logic [PWO-1:0] sat(input logic [WW-1:0] v);
    return (v > MaxOut) ? {PWO{1'b1}} : v[PWO-1:0];
  endfunction

  assign w_s2_load   = !r_out_valid || out_ready_i;
  assign w_s1_load   = !r_s1_valid || w_s2_load;
  assign col_ready_o = w_s1_load;
  assign w_accept    = col_valid_i && col_ready_o;
  assign w_fill_next = col_sol_i ? 2'd1 : ((r_fill == 2'd3) ? 2'd3 : r_fill + 2'd1);
  assign w_issue     = w_accept && (w_fill_next == 2'd3);
  // Only the 2->3 fill transition is the first window of a line.
  assign w_issue_sol = (r_fill == 2'd2) && !col_sol_i;

  // Gradients use the post-shift window: col1, col2 and the incoming column.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_c0[i] = r_col1[i*PW +: PW];
      w_c1[i] = r_col2[i*PW +: PW];
      w_c2[i] = col_i[i*PW +: PW];
    end
    w_gx = (ext(w_c2[0]) + (ext(w_c2[1]) <<< 1) + ext(w_c2[2]))
         - (ext(w_c0[0]) + (ext(w_c0[1]) <<< 1) + ext(w_c0[2]));
    w_gy = (ext(w_c0[2]) + (ext(w_c1[2]) <<< 1) + ext(w_c2[2]))
         - (ext(w_c0[0]) + (ext(w_c1[0]) <<< 1) + ext(w_c2[0]));
  end

  always_comb begin
    w_ax    = r_gx[GW-1] ? GW'(-r_gx) : GW'(r_gx);
    w_ay    = r_gy[GW-1] ? GW'(-r_gy) : GW'(r_gy);
    w_sum   = w_ax + w_ay;
    w_max   = (w_ax >= w_ay) ? w_ax : w_ay;
    w_sum_w = WW'(w_sum);
    w_max_w = WW'(w_max);
    w_thr_w = WW'(r_s1_thr);
    case (r_s1_mode)
      2'b01:   w_pixel_next = (w_sum_w > w_thr_w) ? {PWO{1'b1}} : '0;
      2'b10:   w_pixel_next = sat(w_max_w);
      default: w_pixel_next = sat(w_sum_w);
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_col0      <= '0;
      r_col1      <= '0;
      r_col2      <= '0;
      r_fill      <= '0;
      r_s1_valid  <= 1'b0;
      r_gx        <= '0;
      r_gy        <= '0;
      r_s1_mode   <= '0;
      r_s1_thr    <= '0;
      r_s1_sol    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_pixel <= '0;
      r_out_sol   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_col0 <= r_col1;
        r_col1 <= r_col2;
        r_col2 <= col_i;
        r_fill <= w_fill_next;
      end
      if (w_s1_load) begin
        r_s1_valid <= w_issue;
        if (w_issue) begin
          r_gx      <= w_gx;
          r_gy      <= w_gy;
          r_s1_mode <= mode_i;
          r_s1_thr  <= threshold_i;
          r_s1_sol  <= w_issue_sol;
        end
      end
      if (w_s2_load) begin
        r_out_valid <= r_s1_valid;
        r_out_sol   <= r_s1_valid && r_s1_sol;
        if (r_s1_valid) r_out_pixel <= w_pixel_next;
      end
    end
  end

  assign out_pixel_o = r_out_pixel;
  assign out_sol_o   = r_out_sol;
  assign out_valid_o = r_out_valid;

endmodule
